div_unit: RTL and testbench



---
 rtl/div_unit.sv | 139 +++++++++++++
 tb/tb_div_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ==========================================================================
// Module   : div_unit (with adder32 helper)
// Purpose  : Iterative restoring RV32M DIV/DIVU/REM/REMU unit, 1 bit/clock.
// Revision : 1.0
// ==========================================================================

module adder32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_c_in,
    output logic [31:0] o_sum,
    output logic        o_c_out
);
    assign {o_c_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_c_in};
endmodule

module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_div_data
);
    localparam logic [1:0]      c_st_idle  = 2'd0;
    localparam logic [1:0]      c_st_calc  = 2'd1;
    localparam logic [1:0]      c_st_done  = 2'd2;
    localparam logic [XLEN-1:0] c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_all_ones = {XLEN{1'b1}};

    logic [1:0]      r_state, w_state_nxt;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_rem, r_quo, r_dvs, r_div_data;
    logic            r_is_rem, r_q_neg, r_r_neg;

    logic            w_signed, w_div_zero, w_ovf, w_special, w_last;
    logic [XLEN-1:0] w_neg_a, w_neg_b, w_abs_a, w_abs_b, w_special_res;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_trial, w_rem_nxt, w_quo_nxt;
    logic            w_trial_c, w_no_borrow;
    logic [XLEN-1:0] w_res_raw, w_res_neg, w_result;
    logic            w_unused_ca, w_unused_cb, w_unused_cr;

    // Two's-complement negation: ~x + 1
    adder32 u_neg_a (.i_a(~i_op_a), .i_b('0), .i_c_in(1'b1), .o_sum(w_neg_a), .o_c_out(w_unused_ca));
    adder32 u_neg_b (.i_a(~i_op_b), .i_b('0), .i_c_in(1'b1), .o_sum(w_neg_b), .o_c_out(w_unused_cb));

    assign w_signed   = ~i_div_op[0];
    assign w_abs_a    = (w_signed & i_op_a[XLEN-1]) ? w_neg_a : i_op_a;
    assign w_abs_b    = (w_signed & i_op_b[XLEN-1]) ? w_neg_b : i_op_b;
    assign w_div_zero = (i_op_b == '0);
    assign w_ovf      = w_signed & (i_op_a == c_int_min) & (i_op_b == c_all_ones);
    assign w_special  = w_div_zero | w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = i_div_op[1] ? i_op_a : c_all_ones;
        else
            w_special_res = i_div_op[1] ? '0 : c_int_min;
    end

    // 33-bit trial subtract: low 32 bits via adder, top bit never borrows if set
    assign w_shift     = {r_rem, r_quo[XLEN-1]};
    adder32 u_trial (.i_a(w_shift[XLEN-1:0]), .i_b(~r_dvs), .i_c_in(1'b1),
                     .o_sum(w_trial), .o_c_out(w_trial_c));
    assign w_no_borrow = w_shift[XLEN] | w_trial_c;
    assign w_rem_nxt   = w_no_borrow ? w_trial : w_shift[XLEN-1:0];
    assign w_quo_nxt   = {r_quo[XLEN-2:0], w_no_borrow};
    assign w_last      = (r_cnt == 5'd31);

    assign w_res_raw = r_is_rem ? w_rem_nxt : w_quo_nxt;
    adder32 u_neg_r (.i_a(~w_res_raw), .i_b('0), .i_c_in(1'b1), .o_sum(w_res_neg), .o_c_out(w_unused_cr));
    assign w_result  = (r_is_rem ? r_r_neg : r_q_neg) ? w_res_neg : w_res_raw;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= c_st_idle;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (i_start) w_state_nxt = w_special ? c_st_done : c_st_calc;
            c_st_calc: if (w_last)  w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
        if (i_flush) w_state_nxt = c_st_idle;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_is_rem   <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_div_data <= '0;
        end else if (!i_flush) begin
            case (r_state)
                c_st_idle: begin
                    if (i_start) begin
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                        r_dvs    <= w_abs_b;
                        r_is_rem <= i_div_op[1];
                        r_q_neg  <= w_signed & (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
                        r_r_neg  <= w_signed & i_op_a[XLEN-1];
                        if (w_special) r_div_data <= w_special_res;
                    end
                end
                c_st_calc: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last) r_div_data <= w_result;
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state != c_st_idle);
    assign o_valid    = (r_state == c_st_done) & ~i_flush;
    assign o_div_data = r_div_data;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// tb_div_unit: directed and reference-model checks of div_unit results, latency and aborts.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, valid;
    logic [31:0] div_data;

    int checks = 0;
    int errors = 0;

    div_unit #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_flush(flush),
        .i_div_op(div_op), .i_op_a(op_a), .i_op_b(op_b),
        .o_busy(busy), .o_valid(valid), .o_div_data(div_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present one request for exactly one edge, then scramble the inputs.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_op = op; op_a = a; op_b = b; start = 1'b1;
        step();
        start = 1'b0; div_op = ~op; op_a = ~a; op_b = b ^ 32'h5;
    endtask

    // Latency counts edges from the start edge to the edge that samples o_valid high.
    task automatic wait_valid(output int lat, output bit busy_ok);
        lat = 1; busy_ok = 1'b1;
        while (valid !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a; sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b expected 0", valid); end
        checks++; if (div_data !== 32'h0) begin errors++; $display("FAIL reset data: got %h expected 00000000", div_data); end
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post-reset busy: got %b expected 0", busy); end
    endtask

    // Table-driven op sequence issued back-to-back in the first IDLE cycle after each DONE.
    task automatic test_signed();
        logic [1:0]  ops [2];
        logic [31:0] exps [2];
        int lat; bit bok;
        ops[0] = 2'b00; exps[0] = 32'hFFFF_FFFD;
        ops[1] = 2'b10; exps[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'hFFFF_FFF9, 32'd2);
            wait_valid(lat, bok);
            checks++; if (div_data !== exps[i]) begin errors++; $display("FAIL signed[%0d] data: got %h expected %h", i, div_data, exps[i]); end
            checks++; if (lat != 33) begin errors++; $display("FAIL signed[%0d] latency: got %0d expected 33", i, lat); end
            checks++; if (!bok) begin errors++; $display("FAIL signed[%0d] busy: got dropout expected high", i); end
            step();
            checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL signed[%0d] pulse: got valid=%b busy=%b expected 0 0", i, valid, busy); end
        end
    endtask

    task automatic test_unsigned();
        logic [1:0]  ops [2];
        logic [31:0] exps [2];
        int lat; bit bok;
        ops[0] = 2'b01; exps[0] = 32'h7FFF_FFFF;
        ops[1] = 2'b11; exps[1] = 32'h0000_0001;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'hFFFF_FFFF, 32'd2);
            wait_valid(lat, bok);
            checks++; if (div_data !== exps[i]) begin errors++; $display("FAIL unsigned[%0d] data: got %h expected %h", i, div_data, exps[i]); end
            checks++; if (lat != 33) begin errors++; $display("FAIL unsigned[%0d] latency: got %0d expected 33", i, lat); end
            checks++; if (!bok) begin errors++; $display("FAIL unsigned[%0d] busy: got dropout expected high", i); end
            step();
        end
    endtask

    task automatic test_div_by_zero();
        logic [1:0]  ops [4];
        logic [31:0] as [4];
        logic [31:0] exps [4];
        int lat; bit bok;
        ops[0] = 2'b01; as[0] = 32'd5;          exps[0] = 32'hFFFF_FFFF;
        ops[1] = 2'b11; as[1] = 32'd5;          exps[1] = 32'h0000_0005;
        ops[2] = 2'b00; as[2] = 32'hFFFF_FFFB;  exps[2] = 32'hFFFF_FFFF;
        ops[3] = 2'b10; as[3] = 32'hFFFF_FFFB;  exps[3] = 32'hFFFF_FFFB;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], 32'd0);
            wait_valid(lat, bok);
            checks++; if (div_data !== exps[i]) begin errors++; $display("FAIL divzero[%0d] data: got %h expected %h", i, div_data, exps[i]); end
            checks++; if (lat != 1) begin errors++; $display("FAIL divzero[%0d] latency: got %0d expected 1", i, lat); end
            step();
            checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL divzero[%0d] pulse: got valid=%b busy=%b expected 0 0", i, valid, busy); end
        end
    endtask

    task automatic test_overflow();
        logic [1:0]  ops [4];
        logic [31:0] exps [4];
        int          lats [4];
        int lat; bit bok;
        ops[0] = 2'b00; exps[0] = 32'h8000_0000; lats[0] = 1;
        ops[1] = 2'b10; exps[1] = 32'h0000_0000; lats[1] = 1;
        ops[2] = 2'b01; exps[2] = 32'h0000_0000; lats[2] = 33;
        ops[3] = 2'b11; exps[3] = 32'h8000_0000; lats[3] = 33;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 32'h8000_0000, 32'hFFFF_FFFF);
            wait_valid(lat, bok);
            checks++; if (div_data !== exps[i]) begin errors++; $display("FAIL overflow[%0d] data: got %h expected %h", i, div_data, exps[i]); end
            checks++; if (lat != lats[i]) begin errors++; $display("FAIL overflow[%0d] latency: got %0d expected %0d", i, lat, lats[i]); end
            step();
        end
    endtask

    task automatic test_flush();
        logic [1:0]  ops [2];
        logic [31:0] exps [2];
        int lat; bit bok, seen;
        issue(2'b00, 32'd100, 32'd7);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush busy: got %b expected 0", busy); end
        // Last completed op was REMU 0x80000000 / 0xFFFFFFFF.
        checks++; if (div_data !== 32'h8000_0000) begin errors++; $display("FAIL flush data held: got %h expected 80000000", div_data); end
        seen = 1'b0;
        repeat (40) begin if (valid === 1'b1) seen = 1'b1; step(); end
        checks++; if (seen) begin errors++; $display("FAIL flush valid: got pulse expected none"); end
        ops[0] = 2'b01; exps[0] = 32'd14;
        ops[1] = 2'b11; exps[1] = 32'd2;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'd100, 32'd7);
            wait_valid(lat, bok);
            checks++; if (div_data !== exps[i]) begin errors++; $display("FAIL after-flush[%0d] data: got %h expected %h", i, div_data, exps[i]); end
            checks++; if (lat != 33) begin errors++; $display("FAIL after-flush[%0d] latency: got %0d expected 33", i, lat); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(2'b01, 32'd100, 32'd7);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b expected 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midreset valid: got %b expected 0", valid); end
        checks++; if (div_data !== 32'h0) begin errors++; $display("FAIL midreset data: got %h expected 00000000", div_data); end
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin step(); if (valid === 1'b1 || busy === 1'b1) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL midreset activity: got valid/busy after release expected idle"); end
    endtask

    task automatic test_start_ignored();
        int lat; bit bok;
        issue(2'b01, 32'd1000, 32'd10);
        repeat (5) step();
        div_op = 2'b00; op_a = 32'h1234; op_b = 32'd3; start = 1'b1;
        repeat (2) step();
        start = 1'b0;
        wait_valid(lat, bok);
        checks++; if (div_data !== 32'd100) begin errors++; $display("FAIL busy-start data: got %h expected 00000064", div_data); end
        checks++; if (lat + 7 != 33) begin errors++; $display("FAIL busy-start latency: got %0d expected 33", lat + 7); end
        step();
        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start-with-flush busy: got %b expected 0", busy); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL start-with-flush valid: got %b expected 0", valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] a, b, exp;
        int lat, exp_lat; bit bok;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 4) b = 32'd0;
            if (i == 7) begin op = 2'b10; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 9) begin op = 2'b00; a = 32'hFFFF_FF9C; b = 32'd7; end
            exp = ref_model(op, a, b);
            exp_lat = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
            issue(op, a, b);
            wait_valid(lat, bok);
            checks++; if (div_data !== exp) begin errors++; $display("FAIL random[%0d] op=%0d a=%h b=%h data: got %h expected %h", i, op, a, b, div_data, exp); end
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL random[%0d] latency: got %0d expected %0d", i, lat, exp_lat); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_div_by_zero();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
